// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the program-counter / fetch sequencer.
// Holds the resident program entry points and the branch-target table.
package fetch_pkg;

    localparam int PC_W   = 8;
    localparam int IW     = 9;
    localparam int LUT_AW = 4;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] START_ABC = 8'd0;
    localparam logic [PC_W-1:0] START_STR = 8'd25;
    localparam logic [PC_W-1:0] START_CP  = 8'd44;
    localparam logic [IW-1:0]   HALT_WORD = '0;

    // Packed MSB-first, so entry 15 is written first; entries 12-15 are unused (target 0).
    localparam logic [2**LUT_AW-1:0][PC_W-1:0] BRANCH_LUT = {
        8'd0,  8'd0,  8'd0,  8'd0,
        8'd56, 8'd53, 8'd52, 8'd47,
        8'd45, 8'd39, 8'd38, 8'd28,
        8'd25, 8'd20, 8'd8,  8'd2
    };

    function automatic logic prog_legal(input logic [1:0] sel);
        return (sel != 2'd3);
    endfunction

    function automatic logic [PC_W-1:0] start_addr(input logic [1:0] sel);
        case (sel)
            2'd1:    return START_STR;
            2'd2:    return START_CP;
            default: return START_ABC;
        endcase
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-sequencer bus: control/ROM side (master) and the sequencer itself (slave).
interface pc_fetch_if;
    import fetch_pkg::*;

    logic              start;
    logic [1:0]        prog_sel;
    logic              stall;
    logic              branch_en;
    logic [LUT_AW-1:0] branch_idx;
    logic [IW-1:0]     iptr;
    logic [PC_W-1:0]   PC;
    logic              fetch_valid;
    logic              done;
    logic [CNT_W-1:0]  cycle_count;

    modport master (
        output start, prog_sel, stall, branch_en, branch_idx, iptr,
        input  PC, fetch_valid, done, cycle_count
    );

    modport slave (
        input  start, prog_sel, stall, branch_en, branch_idx, iptr,
        output PC, fetch_valid, done, cycle_count
    );

endinterface

// File: rtl/pc_fetch_branch_lut.sv
// Combinational branch-index to target-PC lookup.
module branch_lut
    import fetch_pkg::*;
(
    input  logic [LUT_AW-1:0] idx,
    output logic [PC_W-1:0]   target
);

    assign target = BRANCH_LUT[idx];

endmodule

// File: rtl/pc_fetch.sv
// PC / fetch sequencer: selects a resident program, steps or branches the PC,
// halts on the all-zero word and counts cycles spent running.
//
// state | meaning
// IDLE  | after reset, waiting for a legal start
// RUN   | fetching; PC advances, branches or holds on stall
// HALT  | halt word seen; PC, done and count frozen until a new start
module pc_fetch
    import fetch_pkg::*;
(
    input  logic     CLK,
    input  logic     reset_n,
    pc_fetch_if.slave bus
);

    state_t           state;
    logic [PC_W-1:0]  pc_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic [PC_W-1:0]  lut_target;
    logic [CNT_W-1:0] cnt_next;
    logic             halt_now;
    logic             start_ok;

    branch_lut u_lut (
        .idx    (bus.branch_idx),
        .target (lut_target)
    );

    assign halt_now = (bus.iptr == HALT_WORD);
    assign start_ok = bus.start && prog_legal(bus.prog_sel);
    assign cnt_next = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pc_q   <= '0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start_ok) begin
                        pc_q   <= start_addr(bus.prog_sel);
                        cnt_q  <= '0;
                        done_q <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Every RUN cycle counts, including stalls and the halting cycle.
                    cnt_q <= cnt_next;
                    if (bus.stall) begin
                        pc_q <= pc_q;
                    end else if (halt_now) begin
                        state  <= HALT;
                        done_q <= 1'b1;
                    end else if (bus.branch_en) begin
                        pc_q <= lut_target;
                    end else begin
                        pc_q <= pc_q + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.PC          = pc_q;
    assign bus.done        = done_q;
    assign bus.cycle_count = cnt_q;
    assign bus.fetch_valid = (state == RUN) && !halt_now;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with a behavioural ROM that returns the halt word
// at one selectable address and a non-zero word everywhere else.
module tb_pc_fetch;
    import fetch_pkg::*;

    logic CLK;
    logic reset_n;
    logic halt_en;
    logic [7:0] halt_addr;

    pc_fetch_if bus ();

    pc_fetch dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.iptr = (halt_en && bus.PC == halt_addr) ? 9'd0 : {1'b1, bus.PC};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic        start;
        logic [1:0]  prog_sel;
        logic        stall;
        logic        branch_en;
        logic [3:0]  branch_idx;
        logic [7:0]  exp_pc;
        logic [15:0] exp_cc;
        logic        exp_done;
        logic        exp_fv;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] pc, input logic [15:0] cc,
                             input logic dn, input logic fv);
        check({name, ".pc"},   {24'd0, bus.PC}, {24'd0, pc});
        check({name, ".cc"},   {16'd0, bus.cycle_count}, {16'd0, cc});
        check({name, ".done"}, {31'd0, bus.done}, {31'd0, dn});
        check({name, ".fv"},   {31'd0, bus.fetch_valid}, {31'd0, fv});
    endtask

    task automatic drive(input logic st, input logic [1:0] sel, input logic stl,
                         input logic ben, input logic [3:0] bidx);
        bus.start      = st;
        bus.prog_sel   = sel;
        bus.stall      = stl;
        bus.branch_en  = ben;
        bus.branch_idx = bidx;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //          st sel stl ben idx  pc      cc      dn  fv
        vecs[0]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'd0,  8'd26, 16'd1,  1'b0, 1'b1};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'd0,  8'd27, 16'd2,  1'b0, 1'b1};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'd0,  8'd28, 16'd3,  1'b0, 1'b1};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'd0,  8'd29, 16'd4,  1'b0, 1'b1};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'd0,  8'd30, 16'd5,  1'b0, 1'b1};
        vecs[5]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'd0,  8'd31, 16'd6,  1'b0, 1'b1};
        vecs[6]  = '{1'b0, 2'd0, 1'b0, 1'b1, 4'd4,  8'd28, 16'd7,  1'b0, 1'b1};
        vecs[7]  = '{1'b0, 2'd0, 1'b1, 1'b0, 4'd0,  8'd28, 16'd8,  1'b0, 1'b1};
        vecs[8]  = '{1'b0, 2'd0, 1'b1, 1'b0, 4'd0,  8'd28, 16'd9,  1'b0, 1'b1};
        vecs[9]  = '{1'b0, 2'd0, 1'b1, 1'b0, 4'd0,  8'd28, 16'd10, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 2'd0, 1'b0, 1'b0, 4'd0,  8'd29, 16'd11, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 1'b1, 4'd7,  8'd45, 16'd12, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 1'b1, 4'd12, 8'd0,  16'd13, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 2'd0, 1'b1, 1'b1, 4'd1,  8'd0,  16'd14, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 2'd0, 1'b0, 1'b1, 4'd11, 8'd56, 16'd15, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 2'd0, 1'b0, 1'b0, 4'd0,  8'd57, 16'd16, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 2'd0, 1'b1, 1'b0, 4'd0,  8'd57, 16'd17, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 2'd0, 1'b0, 1'b1, 4'd1,  8'd57, 16'd18, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 2'd3, 1'b0, 1'b0, 4'd0,  8'd57, 16'd18, 1'b1, 1'b0};

        reset_n   = 1'b0;
        halt_en   = 1'b1;
        halt_addr = 8'd24;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        reset_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            step();
            check_all("idle", 8'd0, 16'd0, 1'b0, 1'b0);
        end

        // Program A: straight line to the halt word at 24
        drive(1'b1, 2'd0, 1'b0, 1'b0, 4'd0);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
        check_all("abc_start", 8'd0, 16'd0, 1'b0, 1'b1);
        for (int k = 1; k <= 24; k++) begin
            step();
            check("abc_pc", {24'd0, bus.PC}, k);
        end
        check("abc_cc24", {16'd0, bus.cycle_count}, 32'd24);
        check("abc_fv_halt_word", {31'd0, bus.fetch_valid}, 32'd0);
        step();
        check_all("abc_halt", 8'd24, 16'd25, 1'b1, 1'b0);
        drive(1'b1, 2'd3, 1'b0, 1'b0, 4'd0);
        step();
        check_all("halt_illegal", 8'd24, 16'd25, 1'b1, 1'b0);

        // Program B from HALT, then the vector table
        halt_addr = 8'd57;
        drive(1'b1, 2'd1, 1'b0, 1'b0, 4'd0);
        step();
        check_all("str_start", 8'd25, 16'd0, 1'b0, 1'b1);
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].start, vecs[i].prog_sel, vecs[i].stall,
                  vecs[i].branch_en, vecs[i].branch_idx);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_cc,
                      vecs[i].exp_done, vecs[i].exp_fv);
        end

        // Program C from HALT, then run to the PC wrap
        halt_en = 1'b0;
        drive(1'b1, 2'd2, 1'b0, 1'b0, 4'd0);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
        check_all("cp_start", 8'd44, 16'd0, 1'b0, 1'b1);
        repeat (211) step();
        check_all("pc_255", 8'd255, 16'd211, 1'b0, 1'b1);
        step();
        check_all("pc_wrap", 8'd0, 16'd212, 1'b0, 1'b1);

        // Reach PC 50, then reset asynchronously with stall/start held
        drive(1'b0, 2'd0, 1'b0, 1'b1, 4'd8);
        step();
        check("br8", {24'd0, bus.PC}, 32'd47);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
        repeat (3) step();
        check_all("pc_50", 8'd50, 16'd216, 1'b0, 1'b1);
        drive(1'b1, 2'd0, 1'b1, 1'b0, 4'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 8'd0, 16'd0, 1'b0, 1'b0);
        step();
        step();
        check_all("rst_held", 8'd0, 16'd0, 1'b0, 1'b0);
        @(negedge CLK);
        reset_n = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
        step();
        check_all("post_rst", 8'd0, 16'd0, 1'b0, 1'b0);

        // Illegal program in IDLE, then a legal start still works
        drive(1'b1, 2'd3, 1'b0, 1'b0, 4'd0);
        step();
        check_all("idle_illegal", 8'd0, 16'd0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
        step();
        check_all("idle_stay", 8'd0, 16'd0, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 1'b0, 1'b0, 4'd0);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 4'd0);
        check_all("restart", 8'd25, 16'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
